// File: rtl/exc_pkg.sv
// Shared definitions for the exception request handshake: FSM states, cause codes, vector.
package exc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HANDLER = 2'd2
   } exc_state_t;

   localparam logic [3:0]  ESTAT_NONE     = 4'h0;
   localparam logic [3:0]  ESTAT_INVOP    = 4'h1;
   localparam logic [3:0]  ESTAT_IRQ_BASE = 4'h8;

   localparam logic [63:0] EXC_VECTOR     = 64'hD8;

endpackage

// File: rtl/irq_sync_edge.sv
// One external interrupt line: 2-FF synchroniser followed by a rising-edge detector.
// rise is a single-cycle pulse, two edges after the line is first sampled high.
module irq_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/exc_request_ctrl.sv
// Initiator side of the exception handshake: collects sync and external sources,
// prioritises them, raises Exc with a frozen EStatus and blocks until ERET.
module exc_request_ctrl
   import exc_pkg::*;
#(
   parameter int NSRC = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inv_opcode,
   input  logic [NSRC-1:0] irq,
   input  logic [NSRC-1:0] irq_mask,
   input  logic            ExcAck,
   input  logic            ERet,
   output logic            Exc,
   output logic [3:0]      EStatus,
   output logic [NSRC-1:0] irq_pending,
   output logic            busy
);

   exc_state_t      state;
   logic            sync_pending;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] clr_irq;
   logic            clr_sync;
   logic            ack_take;
   logic            win_vld;
   logic [3:0]      win_cause;

   for (genvar g = 0; g < NSRC; g++) begin : g_line
      irq_sync_edge u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (irq[g]),
         .rise  (rise[g])
      );
   end

   // The winner's identity is recovered from the latched EStatus, so no separate index register.
   always_comb begin
      eligible  = irq_pending & ~irq_mask;
      win_vld   = sync_pending | (|eligible);
      win_cause = ESTAT_NONE;
      ack_take  = (state == REQ) && ExcAck;
      clr_sync  = ack_take && (EStatus == ESTAT_INVOP);
      clr_irq   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i])
            win_cause = ESTAT_IRQ_BASE + 4'(i);
         clr_irq[i] = ack_take && (EStatus == ESTAT_IRQ_BASE + 4'(i));
      end
      if (sync_pending)
         win_cause = ESTAT_INVOP;
   end

   // A new event in the same cycle as its clear must survive, so set dominates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_pending <= 1'b0;
         irq_pending  <= '0;
      end else begin
         sync_pending <= inv_opcode | (sync_pending & ~clr_sync);
         irq_pending  <= rise | (irq_pending & ~clr_irq);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         Exc     <= 1'b0;
         EStatus <= ESTAT_NONE;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  EStatus <= win_cause;
                  Exc     <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (ExcAck) begin
                  Exc   <= 1'b0;
                  busy  <= 1'b1;
                  state <= HANDLER;
               end
            end
            HANDLER: begin
               if (ERet) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               Exc   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Directed bench for exc_request_ctrl with hand-computed expectations.
module tb_exc_request_ctrl;

   localparam int NSRC = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            inv_opcode = 1'b0;
   logic [NSRC-1:0] irq = '0;
   logic [NSRC-1:0] irq_mask = '0;
   logic            ExcAck = 1'b0;
   logic            ERet = 1'b0;
   logic            Exc;
   logic [3:0]      EStatus;
   logic [NSRC-1:0] irq_pending;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   exc_request_ctrl #(.NSRC(NSRC)) dut (
      .clk         (clk),
      .reset       (reset),
      .inv_opcode  (inv_opcode),
      .irq         (irq),
      .irq_mask    (irq_mask),
      .ExcAck      (ExcAck),
      .ERet        (ERet),
      .Exc         (Exc),
      .EStatus     (EStatus),
      .irq_pending (irq_pending),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic ack_and_eret();
      ExcAck = 1'b1;
      tick();
      ExcAck = 1'b0;
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
   endtask

   initial begin
      int n;
      // Reset state
      #2;
      check("rst_exc", 32'(Exc), 0);
      check("rst_estat", 32'(EStatus), 0);
      check("rst_pend", 32'(irq_pending), 0);
      check("rst_busy", 32'(busy), 0);
      #5 reset = 1'b1;
      tick();
      tick();

      // T1: invalid opcode, ERet in REQ ignored, ExcAck in HANDLER ignored
      inv_opcode = 1'b1;
      tick();
      inv_opcode = 1'b0;
      check("t1_exc_lat0", 32'(Exc), 0);
      tick();
      check("t1_exc", 32'(Exc), 1);
      check("t1_estat", 32'(EStatus), 4'h1);
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
      check("t1_eret_in_req", 32'(Exc), 1);
      check("t1_estat_hold", 32'(EStatus), 4'h1);
      ExcAck = 1'b1;
      tick();
      check("t1_ack_exc", 32'(Exc), 0);
      check("t1_ack_busy", 32'(busy), 1);
      tick();
      ExcAck = 1'b0;
      check("t1_ack_in_hdl", 32'(busy), 1);
      check("t1_ack_in_hdl_exc", 32'(Exc), 0);
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
      check("t1_eret_busy", 32'(busy), 0);
      check("t1_eret_estat", 32'(EStatus), 4'h1);
      tick();
      check("t1_idle_exc", 32'(Exc), 0);

      // T2: irq[2] level held, one request only
      irq = 4'b0100;
      tick();
      tick();
      check("t2_pend_early", 32'(irq_pending), 0);
      tick();
      check("t2_pend", 32'(irq_pending), 4'b0100);
      check("t2_exc_early", 32'(Exc), 0);
      tick();
      check("t2_exc", 32'(Exc), 1);
      check("t2_estat", 32'(EStatus), 4'hA);
      ack_and_eret();
      tick();
      tick();
      check("t2_no_repeat", 32'(Exc), 0);
      check("t2_pend_clr", 32'(irq_pending), 0);

      // T3: sync beats irq[0]; irq[0] follows after ERet
      inv_opcode = 1'b1;
      irq = 4'b0001;
      tick();
      inv_opcode = 1'b0;
      tick();
      check("t3_estat1", 32'(EStatus), 4'h1);
      tick();
      check("t3_pend", 32'(irq_pending), 4'b0001);
      check("t3_frozen", 32'(EStatus), 4'h1);
      ExcAck = 1'b1;
      tick();
      ExcAck = 1'b0;
      check("t3_pend_kept", 32'(irq_pending), 4'b0001);
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
      check("t3_idle_exc", 32'(Exc), 0);
      tick();
      check("t3_exc2", 32'(Exc), 1);
      check("t3_estat2", 32'(EStatus), 4'h8);
      ack_and_eret();
      irq = 4'b0000;
      tick();

      // T4: masked line latched, released by unmask, re-mask in REQ ignored
      irq_mask = 4'b0010;
      irq = 4'b0010;
      tick();
      tick();
      tick();
      check("t4_pend", 32'(irq_pending), 4'b0010);
      tick();
      check("t4_masked", 32'(Exc), 0);
      irq_mask = 4'b0000;
      tick();
      check("t4_unmask_exc", 32'(Exc), 1);
      check("t4_estat", 32'(EStatus), 4'h9);
      irq_mask = 4'b0010;
      tick();
      check("t4_remask", 32'(Exc), 1);
      irq_mask = 4'b0000;
      ack_and_eret();
      irq = 4'b0000;
      tick();

      // T5: ExcAck in IDLE ignored
      ExcAck = 1'b1;
      tick();
      ExcAck = 1'b0;
      check("t5_idle_ack_busy", 32'(busy), 0);
      check("t5_idle_ack_exc", 32'(Exc), 0);

      // T6: inv_opcode coincident with ack of a sync winner stays pending
      inv_opcode = 1'b1;
      tick();
      inv_opcode = 1'b0;
      tick();
      inv_opcode = 1'b1;
      ExcAck = 1'b1;
      tick();
      inv_opcode = 1'b0;
      ExcAck = 1'b0;
      check("t6_busy", 32'(busy), 1);
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
      check("t6_idle", 32'(Exc), 0);
      tick();
      check("t6_exc_again", 32'(Exc), 1);
      check("t6_estat", 32'(EStatus), 4'h1);
      ack_and_eret();
      tick();

      // T7: clear and new edge on the same line in the same cycle
      irq = 4'b0001;
      tick();
      tick();
      tick();
      tick();
      check("t7_exc", 32'(Exc), 1);
      irq = 4'b0000;
      tick();
      tick();
      tick();
      irq = 4'b0001;
      tick();
      tick();
      ExcAck = 1'b1;
      tick();
      ExcAck = 1'b0;
      check("t7_busy", 32'(busy), 1);
      check("t7_set_wins", 32'(irq_pending), 4'b0001);
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
      tick();
      check("t7_exc2", 32'(Exc), 1);
      check("t7_estat2", 32'(EStatus), 4'h8);
      ack_and_eret();
      irq = 4'b0000;
      tick();

      // T8: async reset mid-REQ, then held irq gives exactly one request
      irq = 4'b1000;
      tick();
      tick();
      tick();
      tick();
      check("t8_exc", 32'(Exc), 1);
      check("t8_estat", 32'(EStatus), 4'hB);
      #2 reset = 1'b0;
      #1;
      check("t8_rst_exc", 32'(Exc), 0);
      check("t8_rst_estat", 32'(EStatus), 0);
      check("t8_rst_pend", 32'(irq_pending), 0);
      check("t8_rst_busy", 32'(busy), 0);
      #1 reset = 1'b1;
      n = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (Exc) begin
            n = i;
            break;
         end
      end
      check("t8_relat", 32'(n), 4);
      check("t8_estat2", 32'(EStatus), 4'hB);
      ack_and_eret();
      for (int i = 0; i < 5; i++)
         tick();
      check("t8_single", 32'(Exc), 0);
      check("t8_pend_end", 32'(irq_pending), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
